// File: rtl/comparator_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
// Holds the FSM state enum, one-hot result codes and digit-count helpers.
// No logic; imported by the comparator top and its digit compare stage.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    // One-hot result codes, bit order {L, E, G}.
    localparam logic [2:0] RES_L    = 3'b100;
    localparam logic [2:0] RES_E    = 3'b010;
    localparam logic [2:0] RES_G    = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    // Number of DIGIT-wide digits in a WIDTH-bit operand.
    function automatic int cmp_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter width: holds NDIG-1 with one spare bit.
    function automatic int cmp_cnt_w(input int width, input int digit);
        return $clog2(width / digit) + 1;
    endfunction

endpackage

// File: rtl/comparator_digit_cmp.sv
// Purpose: combinational unsigned compare of one DIGIT-bit digit pair.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: a_dig/b_dig digit inputs; lt/eq/gt mutually exclusive flags.
module comparator_digit_cmp #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    assign lt = (a_dig <  b_dig);
    assign eq = (a_dig == b_dig);
    assign gt = (a_dig >  b_dig);

endmodule

// File: rtl/comparator_nbit_serial.sv
// Purpose: MSB-first serial magnitude compare of two WIDTH-bit operands, DIGIT bits/cycle.
// Latency: 1..NDIG cycles after accept; stops at the first differing digit.
// Backpressure: in_ready only in IDLE; registered one-hot L/E/G held until out_ready.
// Ports: start/in_ready + a/b/signed_mode request; out_valid/out_ready + L/E/G result.
module comparator_nbit_serial
    import comparator_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIGIT     = 1,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             L,
    output logic             E,
    output logic             G
);

    localparam int NDIG  = cmp_ndig(WIDTH, DIGIT);
    localparam int CNT_W = cmp_cnt_w(WIDTH, DIGIT);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("comparator_nbit_serial: DIGIT must divide WIDTH and not exceed it");
    end

    cmp_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       res_q, res_d;

    logic             eff_signed;
    logic [WIDTH-1:0] a_cap, b_cap;
    logic             dig_lt, dig_eq, dig_gt;

    // Flipping the sign bit maps two's complement onto offset binary,
    // so the serial core only ever needs an unsigned compare.
    assign eff_signed = signed_mode & (SIGNED_EN != 0);

    always_comb begin
        a_cap            = a;
        b_cap            = b;
        a_cap[WIDTH-1]   = a[WIDTH-1] ^ eff_signed;
        b_cap[WIDTH-1]   = b[WIDTH-1] ^ eff_signed;
    end

    comparator_digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .a_dig (a_sh_q[WIDTH-1 -: DIGIT]),
        .b_dig (b_sh_q[WIDTH-1 -: DIGIT]),
        .lt    (dig_lt),
        .eq    (dig_eq),
        .gt    (dig_gt)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a_cap;
                    b_sh_d  = b_cap;
                    cnt_d   = CNT_W'(NDIG - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dig_lt) begin
                    res_d   = RES_L;
                    state_d = DONE;
                end else if (dig_gt) begin
                    res_d   = RES_G;
                    state_d = DONE;
                end else if (dig_eq && cnt_q == '0) begin
                    res_d   = RES_E;
                    state_d = DONE;
                end else begin
                    a_sh_d = a_sh_q << DIGIT;
                    b_sh_d = b_sh_q << DIGIT;
                    cnt_d  = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    res_d   = RES_NONE;
                    state_d = IDLE;
                end
            end
            default: begin
                res_d   = RES_NONE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            res_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign L         = res_q[2];
    assign E         = res_q[1];
    assign G         = res_q[0];

endmodule
